// File: rtl/reg_dump_stepper.sv
// reg_dump_stepper: two debounced step buttons walk an index through a
// 32-entry register-file or memory snapshot. Each accepted step converts the
// selected 12-bit entry to four BCD digits with a 12-cycle double-dabble and
// presents the index as two BCD digits alongside.
module reg_dump_stepper #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         btn_r,
  input  logic         btn_m,
  input  logic [383:0] regs,
  input  logic [383:0] mem,
  output logic [3:0]   idx_tens,
  output logic [3:0]   idx_ones,
  output logic [3:0]   bcd_th,
  output logic [3:0]   bcd_hu,
  output logic [3:0]   bcd_te,
  output logic [3:0]   bcd_on,
  output logic [1:0]   led,
  output logic         busy,
  output logic         digits_valid
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  // Bit 0 carries the register button, bit 1 the memory button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_prev;
  logic [CW-1:0] cnt [2];

  logic          step_r;
  logic          step_m;
  logic          accept;

  logic [0:0]    state;
  logic [3:0]    iter;
  logic [27:0]   shreg;
  logic [27:0]   dd_next;
  logic [4:0]    index;
  logic [4:0]    next_index;
  logic          first_done;
  logic [11:0]   entry;

  logic [11:0]   reg_arr [32];
  logic [11:0]   mem_arr [32];

  for (genvar k = 0; k < 32; k++) begin : g_unpack
    assign reg_arr[k] = regs[12*k+11:12*k];
    assign mem_arr[k] = mem[12*k+11:12*k];
  end

  // One double-dabble iteration: add 3 to every BCD digit of 5 or more, then shift left.
  function automatic logic [27:0] dd_step(input logic [27:0] s);
    logic [27:0] t;
    t = s;
    for (int d = 0; d < 4; d++) begin
      if (t[12+4*d +: 4] >= 4'd5) t[12+4*d +: 4] = t[12+4*d +: 4] + 4'd3;
    end
    return {t[26:0], 1'b0};
  endfunction

  // Index 0..31 as tens and ones digits.
  function automatic logic [7:0] idx_to_bcd(input logic [4:0] v);
    logic [3:0] t;
    logic [3:0] o;
    if (v >= 5'd30) begin
      t = 4'd3;
      o = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      t = 4'd2;
      o = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      t = 4'd1;
      o = 4'(v - 5'd10);
    end else begin
      t = 4'd0;
      o = v[3:0];
    end
    return {t, o};
  endfunction

  // Synchronize both buttons and only follow a new level once it has held for the full debounce window.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync1    <= {btn_m, btn_r};
      sync2    <= sync1;
      deb_prev <= deb;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] != deb[b]) begin
          if (cnt[b] == CNT_MAX) begin
            deb[b] <= sync2[b];
            cnt[b] <= '0;
          end else begin
            cnt[b] <= cnt[b] + 1'b1;
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  // Rising debounced levels become single-cycle steps; the register button has priority.
  always_comb begin
    step_r     = deb[0] & ~deb_prev[0];
    step_m     = deb[1] & ~deb_prev[1] & ~step_r;
    accept     = (step_r | step_m) && (state == IDLE);
    next_index = first_done ? index + 5'd1 : 5'd0;
    entry      = step_r ? reg_arr[next_index] : mem_arr[next_index];
    dd_next    = dd_step(shreg);
  end

  assign busy = (state == CONV);

  // Step/convert sequencer: snapshot on accept, run 12 iterations, then publish everything at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      iter         <= '0;
      shreg        <= '0;
      led          <= 2'b00;
      index        <= '0;
      first_done   <= 1'b0;
      idx_tens     <= '0;
      idx_ones     <= '0;
      bcd_th       <= '0;
      bcd_hu       <= '0;
      bcd_te       <= '0;
      bcd_on       <= '0;
      digits_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            led          <= step_r ? 2'b01 : 2'b10;
            index        <= next_index;
            first_done   <= 1'b1;
            shreg        <= {16'd0, entry};
            iter         <= '0;
            digits_valid <= 1'b0;
            state        <= CONV;
          end
        end
        CONV: begin
          shreg <= dd_next;
          if (iter == 4'd11) begin
            {bcd_th, bcd_hu, bcd_te, bcd_on} <= dd_next[27:12];
            {idx_tens, idx_ones}             <= idx_to_bcd(index);
            digits_valid                     <= 1'b1;
            state                            <= IDLE;
          end else begin
            iter <= iter + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_stepper.sv
// tb_reg_dump_stepper: directed scenarios for the stepper with a short
// debounce window; every expected value is written out by hand.
module tb_reg_dump_stepper;

  logic         clock;
  logic         reset;
  logic         btn_r;
  logic         btn_m;
  logic [383:0] regs;
  logic [383:0] mem;
  logic [3:0]   idx_tens;
  logic [3:0]   idx_ones;
  logic [3:0]   bcd_th;
  logic [3:0]   bcd_hu;
  logic [3:0]   bcd_te;
  logic [3:0]   bcd_on;
  logic [1:0]   led;
  logic         busy;
  logic         digits_valid;

  int errors = 0;
  int checks = 0;
  int bc;
  int convs;

  reg_dump_stepper #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .btn_r(btn_r), .btn_m(btn_m),
    .regs(regs), .mem(mem),
    .idx_tens(idx_tens), .idx_ones(idx_ones),
    .bcd_th(bcd_th), .bcd_hu(bcd_hu), .bcd_te(bcd_te), .bcd_on(bcd_on),
    .led(led), .busy(busy), .digits_valid(digits_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Hold the chosen buttons for 10 cycles, release, and let everything settle.
  task automatic press(input bit r, input bit m, output int busy_cycles, output int n_conv);
    bit pb;
    busy_cycles = 0;
    n_conv      = 0;
    pb          = busy;
    btn_r       = r;
    btn_m       = m;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 9) begin
        btn_r = 1'b0;
        btn_m = 1'b0;
      end
      if (busy) busy_cycles++;
      if (busy && !pb) n_conv++;
      pb = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (led !== 2'b00) begin errors++; $display("[TB] FAIL reset_led: got %b expected 00", led); end
    checks++; if ({idx_tens, idx_ones} !== 8'h00) begin errors++; $display("[TB] FAIL reset_idx: got %h expected 00", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd: got %h expected 0000", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (digits_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", digits_valid); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_step();
    regs[11:0] = 12'd1234;
    press(1'b1, 1'b0, bc, convs);
    checks++; if (convs !== 1) begin errors++; $display("[TB] FAIL first_convs: got %0d expected 1", convs); end
    checks++; if (bc !== 12) begin errors++; $display("[TB] FAIL first_busy_len: got %0d expected 12", bc); end
    checks++; if (led !== 2'b01) begin errors++; $display("[TB] FAIL first_led: got %b expected 01", led); end
    checks++; if ({idx_tens, idx_ones} !== 8'h00) begin errors++; $display("[TB] FAIL first_idx: got %h expected 00", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h1234) begin errors++; $display("[TB] FAIL first_bcd: got %h expected 1234", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
    checks++; if (digits_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", digits_valid); end
  endtask

  task automatic test_wrap();
    regs[12*31 +: 12] = 12'd4095;
    regs[12*17 +: 12] = 12'd99;
    for (int i = 1; i <= 31; i++) begin
      press(1'b1, 1'b0, bc, convs);
      if (i == 17) begin
        checks++; if ({idx_tens, idx_ones} !== 8'h17) begin errors++; $display("[TB] FAIL wrap_idx17: got %h expected 17", {idx_tens, idx_ones}); end
        checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h0099) begin errors++; $display("[TB] FAIL wrap_bcd17: got %h expected 0099", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
      end
    end
    checks++; if ({idx_tens, idx_ones} !== 8'h31) begin errors++; $display("[TB] FAIL wrap_idx31: got %h expected 31", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h4095) begin errors++; $display("[TB] FAIL wrap_bcd31: got %h expected 4095", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
    press(1'b1, 1'b0, bc, convs);
    checks++; if ({idx_tens, idx_ones} !== 8'h00) begin errors++; $display("[TB] FAIL wrap_idx0: got %h expected 00", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h1234) begin errors++; $display("[TB] FAIL wrap_bcd0: got %h expected 1234", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
  endtask

  task automatic test_mem_source();
    do_reset();
    regs[12*1 +: 12] = 12'd555;
    mem[12*1 +: 12]  = 12'd7;
    press(1'b1, 1'b0, bc, convs);
    press(1'b0, 1'b1, bc, convs);
    checks++; if (led !== 2'b10) begin errors++; $display("[TB] FAIL mem_led: got %b expected 10", led); end
    checks++; if ({idx_tens, idx_ones} !== 8'h01) begin errors++; $display("[TB] FAIL mem_idx: got %h expected 01", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h0007) begin errors++; $display("[TB] FAIL mem_bcd: got %h expected 0007", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
  endtask

  task automatic test_bounce();
    bit pb;
    do_reset();
    convs = 0;
    pb    = busy;
    for (int c = 0; c < 70; c++) begin
      if (c < 20) btn_r = ((c / 2) % 2) == 0;
      else if (c < 40) btn_r = 1'b1;
      else btn_r = 1'b0;
      tick();
      if (busy && !pb) convs++;
      pb = busy;
    end
    checks++; if (convs !== 1) begin errors++; $display("[TB] FAIL bounce_convs: got %0d expected 1", convs); end
    checks++; if ({idx_tens, idx_ones} !== 8'h00) begin errors++; $display("[TB] FAIL bounce_idx: got %h expected 00", {idx_tens, idx_ones}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem[11:0] = 12'd42;
    press(1'b1, 1'b1, bc, convs);
    checks++; if (led !== 2'b01) begin errors++; $display("[TB] FAIL simul_led: got %b expected 01", led); end
    checks++; if (convs !== 1) begin errors++; $display("[TB] FAIL simul_convs: got %0d expected 1", convs); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h1234) begin errors++; $display("[TB] FAIL simul_bcd: got %h expected 1234", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
  endtask

  task automatic test_back_to_back();
    bit pb;
    int m_age;
    regs[12*1 +: 12] = 12'd2024;
    mem[12*2 +: 12]  = 12'd77;
    bc    = 0;
    convs = 0;
    m_age = -1;
    pb    = busy;
    btn_r = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (c == 9) btn_r = 1'b0;
      if (busy) bc++;
      if (busy && !pb) convs++;
      pb = busy;
      if (busy && m_age < 0) begin
        btn_m = 1'b1;
        m_age = 0;
      end else if (m_age >= 0 && m_age < 5) begin
        m_age++;
        if (m_age == 5) btn_m = 1'b0;
      end
      if (busy && bc == 6) begin
        checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h1234) begin errors++; $display("[TB] FAIL hold_bcd: got %h expected 1234", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
        checks++; if (digits_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid: got %b expected 0", digits_valid); end
      end
    end
    checks++; if (convs !== 1) begin errors++; $display("[TB] FAIL ignore_convs: got %0d expected 1", convs); end
    checks++; if (bc !== 12) begin errors++; $display("[TB] FAIL ignore_busy_len: got %0d expected 12", bc); end
    checks++; if (led !== 2'b01) begin errors++; $display("[TB] FAIL ignore_led: got %b expected 01", led); end
    checks++; if ({idx_tens, idx_ones} !== 8'h01) begin errors++; $display("[TB] FAIL ignore_idx: got %h expected 01", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h2024) begin errors++; $display("[TB] FAIL ignore_bcd: got %h expected 2024", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
  endtask

  task automatic test_reset_abort();
    bit fired;
    regs[12*2 +: 12] = 12'd3210;
    bc    = 0;
    fired = 1'b0;
    btn_r = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c == 9) btn_r = 1'b0;
      if (busy) bc++;
      if (bc == 5 && !fired) begin
        fired = 1'b1;
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (digits_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", digits_valid); end
        checks++; if (led !== 2'b00) begin errors++; $display("[TB] FAIL abort_led: got %b expected 00", led); end
        checks++; if ({idx_tens, idx_ones, bcd_th, bcd_hu, bcd_te, bcd_on} !== 24'h000000) begin errors++; $display("[TB] FAIL abort_digits: got %h expected 000000", {idx_tens, idx_ones, bcd_th, bcd_hu, bcd_te, bcd_on}); end
        reset = 1'b0;
      end
    end
    checks++; if (fired !== 1'b1) begin errors++; $display("[TB] FAIL abort_reached: got %b expected 1", fired); end
    repeat (10) tick();
    press(1'b1, 1'b0, bc, convs);
    checks++; if (led !== 2'b01) begin errors++; $display("[TB] FAIL after_abort_led: got %b expected 01", led); end
    checks++; if ({idx_tens, idx_ones} !== 8'h00) begin errors++; $display("[TB] FAIL after_abort_idx: got %h expected 00", {idx_tens, idx_ones}); end
    checks++; if ({bcd_th, bcd_hu, bcd_te, bcd_on} !== 16'h1234) begin errors++; $display("[TB] FAIL after_abort_bcd: got %h expected 1234", {bcd_th, bcd_hu, bcd_te, bcd_on}); end
  endtask

  // Scenario sequence; each task leaves the buttons released and the design idle.
  initial begin
    reset = 1'b1;
    btn_r = 1'b0;
    btn_m = 1'b0;
    regs  = '0;
    mem   = '0;
    test_reset();
    test_first_step();
    test_wrap();
    test_mem_source();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_stepper.md
REG_DUMP_STEPPER -- requirements
Module: reg_dump_stepper

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a button level change.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn_r  in  1  asynchronous button: select register-file source and step.
REQ-006 btn_m  in  1  asynchronous button: select memory source and step.
REQ-007 regs  in  32x12  register-file snapshot, packed, entry k at bits [12k+11:12k].
REQ-008 mem  in  32x12  data-memory snapshot, same packing as regs.
REQ-009 idx_tens, idx_ones  out  4 each  BCD tens and ones of the displayed index.
REQ-010 bcd_th, bcd_hu, bcd_te, bcd_on  out  4 each  BCD digits of the displayed value.
REQ-011 led  out  2  active source: 00 none, 01 regs, 10 mem.
REQ-012 busy  out  1  high while a conversion is in progress.
REQ-013 digits_valid  out  1  high when the BCD outputs hold a completed conversion.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 A debounced 0->1 transition SHALL produce a one-cycle step pulse; a held button produces no further pulses.
REQ-016 Step pulses arriving while busy=1 SHALL be discarded without changing index, source or led.
REQ-017 If r and m pulses occur in the same cycle, r SHALL win and the m pulse is discarded.
REQ-018 On an accepted step: led <= 01 (r) or 10 (m); the first step after reset selects index 0, every later step selects (index+1) mod 32, so 31 wraps to 0; a source change does not reset the index.
REQ-019 On an accepted step in cycle N, the selected 12-bit entry at the new index SHALL be snapshotted; later input changes do not affect that conversion.
REQ-020 FSM states IDLE, CONV: IDLE->CONV on an accepted step; CONV runs exactly 12 shift-add-3 (double-dabble) iterations, one per cycle, then returns to IDLE.
REQ-021 busy SHALL be 1 for cycles N+1..N+12 exactly, 0 otherwise.
REQ-022 idx_tens, idx_ones and all bcd_* outputs SHALL keep their previous values during CONV and update together at the edge ending cycle N+12, visible from N+13.
REQ-023 digits_valid SHALL be 0 during CONV and 1 from N+13 until the next accepted step or reset.
REQ-024 The maximum input 4095 SHALL yield digits 4,0,9,5; bcd_th never exceeds 4; no overflow handling is needed.
REQ-025 idx_tens SHALL equal index/10 and idx_ones index%10 for the displayed index (0..31).

Reset
REQ-026 While reset=1: led=00, all idx_* and bcd_* = 0, busy=0, digits_valid=0, state IDLE, index=0, first-step flag cleared, debounced levels and counters cleared.
REQ-027 Reset asserted during CONV SHALL abort the conversion; reset values are visible in the cycle after the reset edge, and no partial result is ever presented.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Reset; regs[0]=1234; btn_r high 10 cycles -> exactly one step; led=01; busy high exactly 12 cycles; then digits 1,2,3,4, idx 0,0, digits_valid=1.
REQ-029 regs[31]=4095; 31 further btn_r presses -> last shows idx 3,1 and digits 4,0,9,5; one more press -> idx 0,0 (wrap).
REQ-030 After a reg display at index 0, mem[1]=7; press btn_m -> led=10, idx 0,1, digits 0,0,0,7.
REQ-031 btn_r toggles every 2 cycles for 20 cycles then held high -> exactly one step pulse and one conversion.
REQ-032 btn_r and btn_m rise in the same cycle -> led=01 and one conversion; a btn_m press fully inside busy -> ignored, outputs unchanged.
REQ-033 Reset asserted in the 5th CONV cycle -> next cycle: busy=0, digits_valid=0, led=00, all digits 0; the next btn_r press shows index 0.
